// File: rtl/generic_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : generic_sram_pkg
// Brief   : Shared types and sizing helpers for the byte-enabled SRAM block.
// Rev     : 1.0  initial release
// ============================================================================
package generic_sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_t;

    localparam int SRAM_MIN_READ_LATENCY = 1;
    localparam int SRAM_MAX_READ_LATENCY = 3;

    function automatic int sram_depth(input int address_width);
        return 2 ** address_width;
    endfunction

    function automatic int sram_be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic bit sram_latency_legal(input int read_latency);
        return (read_latency >= SRAM_MIN_READ_LATENCY) &&
               (read_latency <= SRAM_MAX_READ_LATENCY);
    endfunction

endpackage : generic_sram_pkg
`default_nettype wire

// File: rtl/generic_sram_array.sv
`default_nettype none
// ============================================================================
// Module  : generic_sram_array
// Brief   : Byte-enabled single-port storage with a registered read port.
// Rev     : 1.0  initial release
// ============================================================================
module generic_sram_array
    import generic_sram_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH/8-1:0]   i_byte_enable,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic [DATA_WIDTH-1:0]     o_read_data
);

    localparam int DEPTH    = sram_depth(ADDRESS_WIDTH);
    localparam int BE_WIDTH = sram_be_width(DATA_WIDTH);

    // Storage is deliberately left without reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;

    always_ff @(posedge i_clk) begin
        if (i_enable && i_write_enable) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_byte_enable[b]) begin
                    r_mem[i_address][8*b +: 8] <= i_write_data[8*b +: 8];
                end
            end
        end
    end

    // Output register only loads on reads, so it holds the last result otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_read_data <= '0;
        end else if (i_enable && !i_write_enable) begin
            r_read_data <= r_mem[i_address];
        end
    end

    assign o_read_data = r_read_data;

endmodule : generic_sram_array
`default_nettype wire

// File: rtl/generic_sram_byte_en_pipe.sv
`default_nettype none
// ============================================================================
// Module  : generic_sram_byte_en_pipe
// Brief   : Valid/ready byte-enabled SRAM with read pipeline and clear-on-reset.
// Rev     : 1.0  initial release
// ============================================================================
module generic_sram_byte_en_pipe
    import generic_sram_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7,
    parameter int READ_LATENCY  = 1,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH/8-1:0]   i_byte_enable,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic                      o_rsp_valid,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic                      o_init_done
);

    localparam int BE_WIDTH     = sram_be_width(DATA_WIDTH);
    localparam bit C_LATENCY_OK = sram_latency_legal(READ_LATENCY);

    if (!C_LATENCY_OK) begin : g_bad_latency
        $error("generic_sram_byte_en_pipe: READ_LATENCY must be 1, 2 or 3");
    end

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("generic_sram_byte_en_pipe: DATA_WIDTH must be a multiple of 8");
    end

    sram_state_t              r_state;
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;
    logic                     r_req_ready;
    logic                     r_init_done;
    logic                     r_rd_vld0;

    logic                     w_accept;
    logic                     w_arr_en;
    logic                     w_arr_we;
    logic [ADDRESS_WIDTH-1:0] w_arr_addr;
    logic [BE_WIDTH-1:0]      w_arr_be;
    logic [DATA_WIDTH-1:0]    w_arr_wdata;
    logic [DATA_WIDTH-1:0]    w_arr_rdata;

    // Ready is only ever high in RUN, so this also gates requests during INIT.
    assign w_accept = i_req_valid & r_req_ready;

    always_comb begin
        w_arr_en    = w_accept;
        w_arr_we    = i_write_enable;
        w_arr_addr  = i_address;
        w_arr_be    = i_byte_enable;
        w_arr_wdata = i_write_data;
        if (r_state == ST_INIT) begin
            w_arr_en    = 1'b1;
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_addr;
            w_arr_be    = '1;
            w_arr_wdata = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_clr_addr  <= '0;
            r_req_ready <= 1'b0;
            r_init_done <= !INIT_ON_RESET;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
                    if (&r_clr_addr) begin
                        r_state     <= ST_RUN;
                        r_req_ready <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_vld0 <= 1'b0;
        end else begin
            r_rd_vld0 <= w_accept & ~i_write_enable;
        end
    end

    generic_sram_array #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_array (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_enable       (w_arr_en),
        .i_write_enable (w_arr_we),
        .i_address      (w_arr_addr),
        .i_byte_enable  (w_arr_be),
        .i_write_data   (w_arr_wdata),
        .o_read_data    (w_arr_rdata)
    );

    if (READ_LATENCY <= 1) begin : g_lat1
        assign o_rsp_valid = r_rd_vld0;
        assign o_read_data = w_arr_rdata;
    end else begin : g_latn
        logic [READ_LATENCY-1:1] r_vld;
        logic [DATA_WIDTH-1:0]   r_data [1:READ_LATENCY-1];

        // Data stages load only behind a valid, so the last stage holds between responses.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_vld <= '0;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    r_data[i] <= '0;
                end
            end else begin
                r_vld[1] <= r_rd_vld0;
                if (r_rd_vld0) begin
                    r_data[1] <= w_arr_rdata;
                end
                for (int i = 2; i < READ_LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end

        assign o_rsp_valid = r_vld[READ_LATENCY-1];
        assign o_read_data = r_data[READ_LATENCY-1];
    end

    assign o_req_ready = r_req_ready;
    assign o_init_done = r_init_done;

endmodule : generic_sram_byte_en_pipe
`default_nettype wire

// File: tb/tb_generic_sram_byte_en_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_generic_sram_byte_en_pipe
// Brief   : Self-checking bench; latencies 1..3 with clear, plus one no-clear copy.
// Rev     : 1.0  initial release
// ============================================================================
module tb_generic_sram_byte_en_pipe;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        ready [1:4];
    logic        rsp_v [1:4];
    logic [31:0] rdat  [1:4];
    logic        done  [1:4];

    always #5 clk = ~clk;

    generic_sram_byte_en_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1), .INIT_ON_RESET(1'b1)) u_lat1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[1]),
        .i_write_enable(we), .i_address(addr), .i_byte_enable(be), .i_write_data(wdata),
        .o_rsp_valid(rsp_v[1]), .o_read_data(rdat[1]), .o_init_done(done[1]));

    generic_sram_byte_en_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2), .INIT_ON_RESET(1'b1)) u_lat2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[2]),
        .i_write_enable(we), .i_address(addr), .i_byte_enable(be), .i_write_data(wdata),
        .o_rsp_valid(rsp_v[2]), .o_read_data(rdat[2]), .o_init_done(done[2]));

    generic_sram_byte_en_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(3), .INIT_ON_RESET(1'b1)) u_lat3 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[3]),
        .i_write_enable(we), .i_address(addr), .i_byte_enable(be), .i_write_data(wdata),
        .o_rsp_valid(rsp_v[3]), .o_read_data(rdat[3]), .o_init_done(done[3]));

    generic_sram_byte_en_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1), .INIT_ON_RESET(1'b0)) u_noinit (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[4]),
        .i_write_enable(we), .i_address(addr), .i_byte_enable(be), .i_write_data(wdata),
        .o_rsp_valid(rsp_v[4]), .o_read_data(rdat[4]), .o_init_done(done[4]));

    // Reference model: word memory plus a per-edge log of accepted reads.
    logic [31:0] mem    [DEPTH];
    bit          rd_flag[4096];
    logic [31:0] rd_val [4096];
    logic [31:0] last   [1:3];
    int          edge_n;
    int          base_edge;
    int          since_rel;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        since_rel = 0;
        base_edge = edge_n;
        for (int l = 1; l <= 3; l++) last[l] = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    endtask

    task automatic check_outputs();
        for (int l = 1; l <= 3; l++) begin
            automatic int idx = edge_n - l + 1;
            automatic bit ev  = (idx > base_edge) && rd_flag[idx];
            if (ev) last[l] = rd_val[idx];
            check($sformatf("rsp_valid_L%0d@e%0d", l, edge_n), {31'b0, rsp_v[l]}, {31'b0, ev});
            check($sformatf("read_data_L%0d@e%0d", l, edge_n), rdat[l], last[l]);
            check($sformatf("req_ready_L%0d@e%0d", l, edge_n), {31'b0, ready[l]}, {31'b0, since_rel >= DEPTH});
            check($sformatf("init_done_L%0d@e%0d", l, edge_n), {31'b0, done[l]}, {31'b0, since_rel >= DEPTH});
        end
        check($sformatf("req_ready_noinit@e%0d", edge_n), {31'b0, ready[4]}, {31'b0, since_rel >= 1});
        check($sformatf("init_done_noinit@e%0d", edge_n), {31'b0, done[4]}, 32'd1);
    endtask

    // One clock: present a request, advance the model on the edge, then check.
    task automatic step(input logic v, input logic w, input logic [3:0] a,
                        input logic [3:0] m, input logic [31:0] d);
        automatic bit acc;
        req_valid = v;
        we        = w;
        addr      = a;
        be        = m;
        wdata     = d;
        @(posedge clk);
        acc = v && (since_rel >= DEPTH);
        edge_n++;
        rd_flag[edge_n] = acc && !w;
        rd_val[edge_n]  = mem[a];
        if (acc && w) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
        since_rel++;
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom), 32'($urandom));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        edge_n    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        we        = 1'b0;
        addr      = '0;
        be        = '0;
        wdata     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Interrupt the clear after five addresses; it must restart from zero.
        idle(5);
        apply_reset();

        // Requests during the clear are ignored.
        for (int i = 0; i < DEPTH + 4; i++) rand_step();

        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 4'(a), 4'h0, 32'h0);

        step(1'b1, 1'b1, 4'd3, 4'hF, 32'hAABBCCDD);
        step(1'b1, 1'b1, 4'd3, 4'h5, 32'h11223344);
        step(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        idle(3);

        step(1'b1, 1'b1, 4'd1, 4'h0, 32'h0000FFFF);
        step(1'b1, 1'b0, 4'd1, 4'hF, 32'hFFFFFFFF);
        idle(3);

        step(1'b1, 1'b1, 4'd7, 4'hF, 32'h0000005A);
        idle(2);
        step(1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
        idle(4);

        step(1'b1, 1'b1, 4'd2, 4'hF, 32'h00001234);
        step(1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
        idle(4);

        for (int i = 0; i < 150; i++) rand_step();
        idle(3);

        // Two reads in flight on the latency-3 copy when reset hits.
        step(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        step(1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
        apply_reset();
        idle(DEPTH + 2);

        for (int i = 0; i < 60; i++) rand_step();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_generic_sram_byte_en_pipe
`default_nettype wire

// File: doc/generic_sram_byte_en_pipe.md
# generic_sram_byte_en_pipe

Single-port, byte-enabled synchronous SRAM with a valid/ready request interface, a configurable read pipeline (1–3 cycles), and an optional hardware clear-on-reset sequencer. It replaces the fixed-latency byte-enable RAM wrapper wherever a client needs:
- flow control,
- a response strobe, or
- guaranteed-zero contents after reset (cache tag/data arrays, scratchpads).

## Interface
Parameters:
- DATA_WIDTH, 128, data bits; must be a multiple of 8.
- ADDRESS_WIDTH, 7, address bits; DEPTH = 2**ADDRESS_WIDTH words.
- READ_LATENCY, 1, cycles from request acceptance to o_rsp_valid; legal values are 1, 2, 3.
- INIT_ON_RESET, 1, when 1 the block zeroes every word after reset before accepting requests.

Ports:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_write_enable  in  1  1 = write, 0 = read; sampled with i_req_valid.
- i_address  in  ADDRESS_WIDTH  word address.
- i_byte_enable  in  DATA_WIDTH/8  per-byte write mask; bit n covers data bits [8n+7:8n].
- i_write_data  in  DATA_WIDTH  write data.
- o_rsp_valid  out  1  single-cycle strobe; o_read_data holds a read result.
- o_read_data  out  DATA_WIDTH  read data.
- o_init_done  out  1  clear sequence complete; stays high until the next reset.

## Operation
- FSM states:
  - INIT: clear sequencer active.
  - RUN: normal operation.
- Reset (async assert) forces state INIT if INIT_ON_RESET=1, else RUN.
- Reset forces these output values:
  - o_req_ready=0, o_rsp_valid=0, o_read_data=0.
  - o_init_done=0 if INIT_ON_RESET=1, else 1.
  - Clear address counter=0.
  - All read-pipeline valid bits cleared.
- INIT:
  - Each cycle, writes all-zero data with all byte enables set to the counter address, then increments the counter.
  - The write to DEPTH-1 moves the FSM to RUN. Counter wrap to 0 is not observable.
  - o_req_ready=0; i_req_valid is ignored.
- RUN:
  - o_req_ready=1 every cycle. There is no internal backpressure, and the block has no output-side ready.
  - Accept = i_req_valid & o_req_ready.
  - Write accept:
    - Byte n of the addressed word is updated iff i_byte_enable[n]=1; other bytes are preserved.
    - An all-zero mask is a no-op.
    - No response is generated.
  - Read accept:
    - Issues a read to the array.
    - The result propagates through READ_LATENCY-1 additional register stages, each with a valid bit.
- Between responses, o_read_data holds its last value; o_rsp_valid=0.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the written (merged) data.
  - Only one operation can be accepted per cycle, so no same-cycle conflict exists.
- Reset mid-INIT restarts the clear at address 0.
- Reset during RUN drops all in-flight reads: no o_rsp_valid appears after reset. Array contents are undefined if INIT_ON_RESET=0.
- i_byte_enable and i_write_data are ignored on reads.

## Timing
- With INIT_ON_RESET=1, after reset deassertion:
  - The first rising edge clears address 0.
  - Edge DEPTH clears address DEPTH-1.
  - o_init_done and o_req_ready are high from the cycle following edge DEPTH.
- Read accepted at edge T: o_rsp_valid=1 and o_read_data valid during the cycle after edge T+READ_LATENCY-1. Latency 1 = array output register only.
- Write accepted at edge T: array updated at edge T; visible to a read accepted at edge T+1.
- Throughput: one request per cycle in RUN, including back-to-back reads, writes, or any mix.

## Structure
- Package generic_sram_pkg:
  - State enum {INIT, RUN}.
  - Function/localparam for DEPTH and byte-enable width.
  - Legal-READ_LATENCY check constant.
- Sub-module generic_sram_array: byte-enabled single-port array with registered read and no reset on storage. Holds only the memory so synthesis infers block RAM.
- Top level holds:
  - FSM.
  - Clear counter.
  - Write mux (clear path vs client path).
  - Valid/data pipeline.

## Test plan
- Clear check: INIT_ON_RESET=1, ADDRESS_WIDTH=4.
  - Release reset → o_req_ready rises exactly 16 edges later.
  - Reads of all 16 addresses return 0.
- Byte merge: DATA_WIDTH=32.
  - Write 0xAABBCCDD mask 0xF to addr 3, then 0x11223344 mask 0x5 to addr 3.
  - Read addr 3 → 0xAA22CC44.
- Latency sweep: READ_LATENCY=1,2,3.
  - Write 0x5A to addr 7, read addr 7 at edge T.
  - o_rsp_valid high exactly in the cycle after edge T+L-1, data 0x5A.
- Back-to-back: write addr 2 = 0x1234 at edge T, read addr 2 at edge T+1 → returns 0x1234.
  - Streaming 8 consecutive reads yields 8 consecutive o_rsp_valid pulses.
- Reset mid-operation:
  - Assert i_rst at INIT counter=5 → clear restarts at 0; completes DEPTH edges after release.
  - Assert i_rst with two reads in flight (READ_LATENCY=3) → no o_rsp_valid after reset; o_read_data=0.
- Zero mask: write 0xFFFF mask 0 to addr 1 after clear → read addr 1 returns 0.
